// File: rtl/val_pkg.sv
// Shared types and limits for the magnitude/sign to 8-bit word encoder.
package val_pkg;

    parameter int unsigned VAL_W = 8;

    localparam logic [VAL_W-1:0] POS_MAX = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic [VAL_W-1:0] NEG_MAX = {1'b1, {(VAL_W-1){1'b0}}};
    localparam logic [VAL_W-1:0] SAT_POS = POS_MAX;
    localparam logic [VAL_W-1:0] SAT_NEG = NEG_MAX;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

endpackage

// File: rtl/serial_negate.sv
// Bit-serial two's-complement negation, LSB first: copy up to and including
// the first 1, invert every bit after it.
module serial_negate (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic en_i,
    input  logic bit_i,
    output logic bit_o
);

    logic seen_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_q <= 1'b0;
        end else if (start_i) begin
            seen_q <= 1'b0;
        end else if (en_i && bit_i) begin
            seen_q <= 1'b1;
        end
    end

    assign bit_o = seen_q ? ~bit_i : bit_i;

endmodule

// File: rtl/compose_val.sv
// Encodes a magnitude/sign/mode triple into an unsigned or two's-complement word,
// saturating and flagging out-of-range inputs; negation runs bit-serially.
module compose_val
    import val_pkg::*;
#(
    parameter int unsigned Width = VAL_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] mag_i,
    input  logic             neg_i,
    input  logic             mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] data_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [Width-1:0] PosMax = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] NegMax = {1'b1, {(Width-1){1'b0}}};
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] shift_q;
    logic [Width-1:0] data_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             to_conv;
    logic [Width-1:0] direct_data;
    logic             direct_ovf;
    logic             neg_bit;

    assign accept = (state_q == StIdle) && in_valid_i;

    // Classify the input: everything except an in-range negative resolves in one step.
    always_comb begin
        to_conv     = 1'b0;
        direct_data = mag_i;
        direct_ovf  = 1'b0;
        if (mode_i) begin
            if (!neg_i) begin
                if (mag_i > PosMax) begin
                    direct_data = PosMax;
                    direct_ovf  = 1'b1;
                end
            end else if (mag_i > NegMax) begin
                direct_data = NegMax;
                direct_ovf  = 1'b1;
            end else if (mag_i == '0) begin
                direct_data = '0;
            end else begin
                to_conv = 1'b1;
            end
        end
    end

    serial_negate u_serial_negate (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (accept),
        .en_i    (state_q == StConv),
        .bit_i   (shift_q[0]),
        .bit_o   (neg_bit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        if (to_conv) begin
                            shift_q <= mag_i;
                            ovf_q   <= 1'b0;
                            state_q <= StConv;
                        end else begin
                            data_q      <= direct_data;
                            ovf_q       <= direct_ovf;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StConv: begin
                    shift_q <= shift_q >> 1;
                    data_q  <= {neg_bit, data_q[Width-1:1]};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_compose_val.sv
// Directed and swept checks of compose_val against an arithmetic reference model.
module tb_compose_val;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mag;
    logic       neg;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data;
    logic       ovf;

    int total;
    int bad;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        int         lat;
        logic [7:0] mag;
        logic       neg;
        logic       mode;
    } exp_t;

    exp_t sb[$];

    compose_val #(.Width(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mag_i       (mag),
        .neg_i       (neg),
        .mode_i      (mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] m, input logic n, input logic md);
        exp_t e;
        int   v;
        e.mag = m; e.neg = n; e.mode = md;
        e.ovf = 1'b0;
        e.lat = 1;
        v = int'(m);
        if (!md) begin
            e.data = m;
        end else if (!n) begin
            if (v > 127) begin e.data = 8'h7F; e.ovf = 1'b1; end
            else e.data = m;
        end else if (v > 128) begin
            e.data = 8'h80; e.ovf = 1'b1;
        end else if (v == 0) begin
            e.data = 8'h00;
        end else begin
            e.data = 8'((256 - v) % 256);
            e.lat  = 9;
        end
        return e;
    endfunction

    // Drive one word, wait for the result, hold back-pressure for `hold` cycles,
    // then complete the output transfer. Called #1 after a rising edge.
    task automatic txn(input logic [7:0] m, input logic n, input logic md, input int hold);
        exp_t e;
        int   lat;
        logic [7:0] d0;
        logic       o0;
        int         sv;
        sb.push_back(model(m, n, md));
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mag = m; neg = n; mode = md;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mag = 8'($urandom); neg = ~n; mode = ~md;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("latency", 32'(lat), 32'(e.lat));
        chk("data", 32'(data), 32'(e.data));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        if (e.mode && !e.ovf) begin
            // Decode back to magnitude/sign; zero always decodes as positive.
            sv = data[7] ? (256 - int'(data)) : int'(data);
            chk("decode_mag", 32'(sv), 32'(e.mag));
            chk("decode_neg", 32'(data[7]), 32'(e.neg && e.mag != 0));
        end
        d0 = data; o0 = ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0]; mag = 8'($urandom); neg = 1'b1; mode = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(data), 32'(d0));
            chk("hold_ovf", 32'(ovf), 32'(o0));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mag = 8'h00; neg = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        txn(8'hC8, 1'b1, 1'b0, 0);
        txn(8'd5, 1'b1, 1'b1, 0);
        txn(8'd128, 1'b1, 1'b1, 0);
        txn(8'd1, 1'b1, 1'b1, 0);
        txn(8'd200, 1'b0, 1'b1, 0);
        txn(8'd129, 1'b1, 1'b1, 0);
        txn(8'd0, 1'b1, 1'b1, 0);
        txn(8'd127, 1'b0, 1'b1, 0);
        txn(8'd255, 1'b1, 1'b1, 0);
        txn(8'd100, 1'b1, 1'b1, 20);
        txn(8'd200, 1'b0, 1'b1, 20);

        // Reset during the fourth CONV cycle discards the conversion.
        in_valid = 1'b1; mag = 8'd37; neg = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        txn(8'd37, 1'b1, 1'b1, 0);
        chk("sb_empty_rst", 32'(sb.size()), 32'd0);

        // Sweep every in-range magnitude/sign pair in signed mode, in shuffled order.
        begin
            int order[$];
            for (int i = 0; i < 256; i++) begin
                if (i <= 127) order.push_back(i);
                if (i >= 1 && i <= 128) order.push_back(i + 256);
            end
            order.shuffle();
            foreach (order[k]) begin
                txn(8'(order[k] % 256), order[k] >= 256, 1'b1, 0);
            end
        end
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
